// File: rtl/reg_file_clr_pkg.sv
// Shared sizing, FSM state encoding and ALU op codes for the register file slice.
package reg_file_clr_pkg;

    localparam int unsigned RF_WIDTH = 32;
    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_DEPTH = 2 ** RF_AW;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Op codes understood by the downstream yAlu stage.
    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/reg_file_clr_if.sv
// Read/write port bundle between the writeback/decode side and the register file.
interface reg_file_clr_if
    import reg_file_clr_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned AW    = RF_AW
);

    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] wd;
    logic             we;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             busy;
    logic             wr_err;

    modport master (
        output rs1, rs2, rd, wd, we,
        input  rd1, rd2, busy, wr_err
    );

    modport slave (
        input  rs1, rs2, rd, wd, we,
        output rd1, rd2, busy, wr_err
    );

endinterface

// File: rtl/reg_file_clr_fsm.sv
// Post-reset clear sequencer: walks every entry once, then hands the array to normal use.
module reg_file_clr_fsm
    import reg_file_clr_pkg::*;
#(
    parameter int unsigned DEPTH = RF_DEPTH,
    parameter int unsigned AW    = RF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          wr_err
);

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state == ST_CLEAR) && we;
            if (state == ST_CLEAR) begin
                cnt <= cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    // The array is left alone while reset is held; clearing starts on the first free edge.
    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy && !reset;
    assign clr_addr = cnt;
    assign wr_err   = err_q;

endmodule

// File: rtl/reg_file_clr.sv
// 2R1W register file with registered reads, write-to-read forwarding and hardware clear after reset.
module reg_file_clr
    import reg_file_clr_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned DEPTH = RF_DEPTH,
    parameter int unsigned AW    = RF_AW
) (
    input  logic           clk,
    input  logic           reset,
    reg_file_clr_if.slave  bus
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] val1, val2;
    logic [WIDTH-1:0] rd1_q, rd2_q;
    logic             busy, clr_we, wr_err;
    logic [AW-1:0]    clr_addr;
    logic             run_we;

    reg_file_clr_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .we       (bus.we),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .wr_err   (wr_err)
    );

    assign run_we = !busy && bus.we && (bus.rd != '0);

    // Same-cycle write wins over the array so a reader never sees stale data.
    always_comb begin
        val1 = mem[bus.rs1];
        if (bus.rs1 == '0) begin
            val1 = '0;
        end else if (bus.we && (bus.rd == bus.rs1)) begin
            val1 = bus.wd;
        end
        val2 = mem[bus.rs2];
        if (bus.rs2 == '0) begin
            val2 = '0;
        end else if (bus.we && (bus.rd == bus.rs2)) begin
            val2 = bus.wd;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (run_we) begin
            mem[bus.rd] <= bus.wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || busy) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            rd1_q <= val1;
            rd2_q <= val2;
        end
    end

    assign bus.rd1    = rd1_q;
    assign bus.rd2    = rd2_q;
    assign bus.busy   = busy;
    assign bus.wr_err = wr_err;

endmodule
